// File: rtl/dma_bus_arb_ctrl.sv
// Multi-channel DMA bus controller: arbitrates N_CH requesters, requests the bus with an
// ack timeout, runs a BURST_LEN-beat transfer and returns a one-cycle completion pulse.
module dma_bus_arb_ctrl #(
    parameter int N_CH        = 4,
    parameter int BURST_LEN   = 4,
    parameter int ACK_TIMEOUT = 5,
    parameter int ARB_MODE    = 0,
    localparam int CW         = $clog2(N_CH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] dma_req_i,
    output logic [N_CH-1:0] dma_ack_o,
    output logic            bus_req_o,
    input  logic            bus_ack_i,
    output logic            bus_enb_o,
    output logic            mem_enb_o,
    output logic            done_o,
    output logic            timeout_err_o,
    output logic [CW-1:0]   grant_id_o,
    output logic [2:0]      state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_XFER = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    localparam int WW = $clog2(ACK_TIMEOUT + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   last_q, last_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [N_CH-1:0] dma_ack_q, dma_ack_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_enb_q, bus_enb_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [CW-1:0]   win;
    logic [CW-1:0]   idx;
    logic            found;

    // Winner search: round-robin starts just above the last served channel.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ARB_MODE == 1) idx = CW'(i);
            else               idx = CW'((int'(last_q) + 1 + i) % N_CH);
            if (!found && dma_req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= CW'(N_CH - 1);
            wait_q    <= '0;
            beat_q    <= '0;
            dma_ack_q <= '0;
            bus_req_q <= 1'b0;
            bus_enb_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wait_q    <= wait_d;
            beat_q    <= beat_d;
            dma_ack_q <= dma_ack_d;
            bus_req_q <= bus_req_d;
            bus_enb_q <= bus_enb_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (|dma_req_i) begin
                    grant_d = win;
                    wait_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_ack_i) begin
                    beat_d  = '0;
                    state_d = S_XFER;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_XFER: begin
                if (beat_q == BEAT_LAST) state_d = S_DONE;
                else                     beat_d  = beat_q + 1'b1;
            end
            // A timed-out channel also becomes "last", so it loses its turn.
            S_DONE, S_ERR: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output comes straight from a flop.
    always_comb begin
        bus_req_d = (state_d == S_REQ) || (state_d == S_XFER);
        bus_enb_d = (state_d == S_XFER);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
        dma_ack_d = '0;
        if (state_d == S_DONE) dma_ack_d[grant_d] = 1'b1;
    end

    assign dma_ack_o     = dma_ack_q;
    assign bus_req_o     = bus_req_q;
    assign bus_enb_o     = bus_enb_q;
    assign mem_enb_o     = bus_enb_q;
    assign done_o        = done_q;
    assign timeout_err_o = err_q;
    assign grant_id_o    = grant_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_dma_bus_arb_ctrl.sv
// Directed bench for dma_bus_arb_ctrl: default round-robin instance, a fixed-priority
// instance and a single-beat instance share one stimulus stream.
module tb_dma_bus_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] dma_req = '0;
    logic       bus_ack = 1'b0;

    logic [3:0] m_dma_ack, f_dma_ack, b_dma_ack;
    logic       m_bus_req, f_bus_req, b_bus_req;
    logic       m_bus_enb, f_bus_enb, b_bus_enb;
    logic       m_mem_enb, f_mem_enb, b_mem_enb;
    logic       m_done, f_done, b_done;
    logic       m_err, f_err, b_err;
    logic [1:0] m_gid, f_gid, b_gid;
    logic [2:0] m_state, f_state, b_state;

    int checks = 0;
    int errors = 0;
    int rr_exp[5];

    always #5 clk = ~clk;

    dma_bus_arb_ctrl #(.N_CH(4), .BURST_LEN(4), .ACK_TIMEOUT(5), .ARB_MODE(0)) u_main (
        .clk_i(clk), .rst_i(rst), .dma_req_i(dma_req), .dma_ack_o(m_dma_ack),
        .bus_req_o(m_bus_req), .bus_ack_i(bus_ack), .bus_enb_o(m_bus_enb),
        .mem_enb_o(m_mem_enb), .done_o(m_done), .timeout_err_o(m_err),
        .grant_id_o(m_gid), .state_o(m_state)
    );

    dma_bus_arb_ctrl #(.N_CH(4), .BURST_LEN(4), .ACK_TIMEOUT(5), .ARB_MODE(1)) u_fixed (
        .clk_i(clk), .rst_i(rst), .dma_req_i(dma_req), .dma_ack_o(f_dma_ack),
        .bus_req_o(f_bus_req), .bus_ack_i(bus_ack), .bus_enb_o(f_bus_enb),
        .mem_enb_o(f_mem_enb), .done_o(f_done), .timeout_err_o(f_err),
        .grant_id_o(f_gid), .state_o(f_state)
    );

    dma_bus_arb_ctrl #(.N_CH(4), .BURST_LEN(1), .ACK_TIMEOUT(5), .ARB_MODE(0)) u_b1 (
        .clk_i(clk), .rst_i(rst), .dma_req_i(dma_req), .dma_ack_o(b_dma_ack),
        .bus_req_o(b_bus_req), .bus_ack_i(bus_ack), .bus_enb_o(b_bus_enb),
        .mem_enb_o(b_mem_enb), .done_o(b_done), .timeout_err_o(b_err),
        .grant_id_o(b_gid), .state_o(b_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dma_req = '0;
        bus_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dma_req = 4'b1111;
        bus_ack = 1'b1;
        tick();
        tick();
        checks++;
        if ({m_dma_ack, m_bus_req, m_bus_enb, m_mem_enb, m_done, m_err, m_gid, m_state} !== 15'd0) begin
            errors++;
            $display("FAIL reset_main outputs=%b want all zero",
                     {m_dma_ack, m_bus_req, m_bus_enb, m_mem_enb, m_done, m_err, m_gid, m_state});
        end
        checks++;
        if ({f_dma_ack, f_bus_req, f_bus_enb, b_dma_ack, b_bus_req, b_bus_enb} !== 12'd0) begin
            errors++;
            $display("FAIL reset_others outputs=%b want all zero",
                     {f_dma_ack, f_bus_req, f_bus_enb, b_dma_ack, b_bus_req, b_bus_enb});
        end
        rst = 1'b0;
        dma_req = '0;
        bus_ack = 1'b0;
    endtask

    task automatic test_single_grant();
        do_reset();
        dma_req = 4'b0100;
        tick();
        checks++;
        if (m_bus_req !== 1'b1 || m_gid !== 2'd2 || m_bus_enb !== 1'b0) begin
            errors++;
            $display("FAIL t1_req bus_req=%b grant_id=%0d bus_enb=%b want 1/2/0", m_bus_req, m_gid, m_bus_enb);
        end
        dma_req = '0;
        tick();
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_bus_enb !== 1'b1 || m_mem_enb !== 1'b1 || m_bus_req !== 1'b1 || m_done !== 1'b0) begin
                errors++;
                $display("FAIL t1_beat%0d enb=%b mem=%b req=%b done=%b want 1/1/1/0",
                         i, m_bus_enb, m_mem_enb, m_bus_req, m_done);
            end
            tick();
        end
        checks++;
        if (m_done !== 1'b1 || m_dma_ack !== 4'b0100 || m_bus_req !== 1'b0 || m_bus_enb !== 1'b0) begin
            errors++;
            $display("FAIL t1_done done=%b dma_ack=%b req=%b enb=%b want 1/0100/0/0",
                     m_done, m_dma_ack, m_bus_req, m_bus_enb);
        end
        tick();
        checks++;
        if (m_done !== 1'b0 || m_dma_ack !== 4'b0000) begin
            errors++;
            $display("FAIL t1_after done=%b dma_ack=%b want 0/0000", m_done, m_dma_ack);
        end
    endtask

    task automatic test_rr_fairness();
        int n_m;
        int n_f;
        n_m = 0;
        n_f = 0;
        do_reset();
        dma_req = 4'b1111;
        bus_ack = 1'b1;
        for (int c = 0; c < 80 && n_m < 5; c++) begin
            tick();
            checks++;
            if (m_done !== (|m_dma_ack) || (m_bus_enb && !m_bus_req) || $countones(m_dma_ack) > 1) begin
                errors++;
                $display("FAIL t2_invariant done=%b dma_ack=%b enb=%b req=%b", m_done, m_dma_ack, m_bus_enb, m_bus_req);
            end
            if (m_done === 1'b1) begin
                checks++;
                if (m_gid !== rr_exp[n_m][1:0] || m_dma_ack !== (4'b0001 << rr_exp[n_m])) begin
                    errors++;
                    $display("FAIL t2_rr_grant%0d grant_id=%0d dma_ack=%b want %0d", n_m, m_gid, m_dma_ack, rr_exp[n_m]);
                end
                n_m++;
            end
            if (f_done === 1'b1) begin
                checks++;
                if (f_gid !== 2'd0 || f_dma_ack !== 4'b0001) begin
                    errors++;
                    $display("FAIL t2_fixed_grant grant_id=%0d dma_ack=%b want 0/0001", f_gid, f_dma_ack);
                end
                n_f++;
            end
        end
        checks++;
        if (n_m != 5 || n_f != 5) begin
            errors++;
            $display("FAIL t2_count rr_grants=%0d fixed_grants=%0d want 5/5", n_m, n_f);
        end
        dma_req = '0;
        bus_ack = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        dma_req = 4'b0110;
        bus_ack = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m_bus_req !== 1'b1 || m_err !== 1'b0 || m_gid !== 2'd1) begin
                errors++;
                $display("FAIL t3_wait%0d bus_req=%b err=%b grant_id=%0d want 1/0/1", i, m_bus_req, m_err, m_gid);
            end
            tick();
        end
        checks++;
        if (m_err !== 1'b1 || m_bus_req !== 1'b0 || m_dma_ack !== 4'b0000 || m_done !== 1'b0) begin
            errors++;
            $display("FAIL t3_err err=%b req=%b dma_ack=%b done=%b want 1/0/0000/0", m_err, m_bus_req, m_dma_ack, m_done);
        end
        tick();
        checks++;
        if (m_err !== 1'b0 || m_bus_req !== 1'b0) begin
            errors++;
            $display("FAIL t3_idle err=%b req=%b want 0/0", m_err, m_bus_req);
        end
        tick();
        checks++;
        if (m_gid !== 2'd2 || m_bus_req !== 1'b1) begin
            errors++;
            $display("FAIL t3_next grant_id=%0d req=%b want 2/1", m_gid, m_bus_req);
        end
        dma_req = '0;
    endtask

    task automatic test_late_ack();
        logic seen_err;
        seen_err = 1'b0;
        do_reset();
        dma_req = 4'b0001;
        tick();
        dma_req = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_err = seen_err | m_err;
        end
        checks++;
        if (m_bus_req !== 1'b1 || m_bus_enb !== 1'b0) begin
            errors++;
            $display("FAIL t4_req5 req=%b enb=%b want 1/0", m_bus_req, m_bus_enb);
        end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        seen_err = seen_err | m_err;
        checks++;
        if (m_bus_enb !== 1'b1 || m_err !== 1'b0) begin
            errors++;
            $display("FAIL t4_xfer enb=%b err=%b want 1/0", m_bus_enb, m_err);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_err = seen_err | m_err;
        end
        checks++;
        if (m_done !== 1'b1 || m_dma_ack !== 4'b0001 || seen_err !== 1'b0) begin
            errors++;
            $display("FAIL t4_done done=%b dma_ack=%b any_err=%b want 1/0001/0", m_done, m_dma_ack, seen_err);
        end
    endtask

    task automatic test_reset_mid_xfer();
        logic seen_done;
        seen_done = 1'b0;
        do_reset();
        dma_req = 4'b0010;
        bus_ack = 1'b1;
        tick();
        tick();
        bus_ack = 1'b0;
        dma_req = '0;
        tick();
        tick();
        checks++;
        if (m_gid !== 2'd1 || m_bus_enb !== 1'b1) begin
            errors++;
            $display("FAIL t5_pre grant_id=%0d enb=%b want 1/1", m_gid, m_bus_enb);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({m_dma_ack, m_bus_req, m_bus_enb, m_mem_enb, m_done, m_err, m_gid} !== 12'd0) begin
            errors++;
            $display("FAIL t5_reset outputs=%b want all zero",
                     {m_dma_ack, m_bus_req, m_bus_enb, m_mem_enb, m_done, m_err, m_gid});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_done = seen_done | m_done | (|m_dma_ack);
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL t5_no_done saw_done=%b want 0", seen_done);
        end
        dma_req = 4'b1111;
        tick();
        checks++;
        if (m_gid !== 2'd0 || m_bus_req !== 1'b1) begin
            errors++;
            $display("FAIL t5_regrant grant_id=%0d req=%b want 0/1", m_gid, m_bus_req);
        end
        dma_req = '0;
    endtask

    task automatic test_back_to_back();
        int rise_t[4];
        int n_rise;
        int n_enb;
        int n_done;
        logic prev_req;
        logic prev_enb;
        n_rise = 0;
        n_enb = 0;
        n_done = 0;
        prev_req = 1'b0;
        prev_enb = 1'b0;
        do_reset();
        dma_req = 4'b1111;
        bus_ack = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (b_bus_req && !prev_req && n_rise < 4) begin
                rise_t[n_rise] = c;
                n_rise++;
            end
            if (b_bus_enb) n_enb++;
            checks++;
            if ((b_bus_enb && prev_enb) || (b_bus_enb && !b_bus_req)) begin
                errors++;
                $display("FAIL t6_enb_pulse cycle=%0d enb=%b prev_enb=%b req=%b", c, b_bus_enb, prev_enb, b_bus_req);
            end
            if (b_done === 1'b1) begin
                checks++;
                if (n_done < 4 && (b_gid !== 2'(n_done) || b_dma_ack !== (4'b0001 << n_done))) begin
                    errors++;
                    $display("FAIL t6_grant%0d grant_id=%0d dma_ack=%b want %0d", n_done, b_gid, b_dma_ack, n_done);
                end
                n_done++;
            end
            prev_req = b_bus_req;
            prev_enb = b_bus_enb;
        end
        checks++;
        if (n_rise != 4 || n_enb != 4 || n_done != 4) begin
            errors++;
            $display("FAIL t6_counts rises=%0d enb_cycles=%0d dones=%0d want 4/4/4", n_rise, n_enb, n_done);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (rise_t[i] - rise_t[i-1] != 4) begin
                    errors++;
                    $display("FAIL t6_spacing%0d gap=%0d want 4", i, rise_t[i] - rise_t[i-1]);
                end
            end
        end
        dma_req = '0;
        bus_ack = 1'b0;
    endtask

    initial begin
        rr_exp = '{0, 1, 2, 3, 0};
        test_reset();
        test_single_grant();
        test_rr_fairness();
        test_timeout();
        test_late_ack();
        test_reset_mid_xfer();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
